reg_apb_master: RTL and testbench

Register-access APB initiator: accepts single read/write commands on a valid/ready request channel, runs one APB4 SETUP/ACCESS transfer per command, and returns read data and error status on a valid/ready response channel. It sits in front of the generated APB register-bank responders and is how firmware-facing or test-side logic reaches a register space over APB. A bounded wait-state watchdog keeps a hung responder from stalling the requester forever.

---
 rtl/reg_apb_pkg.sv | 13 +
 rtl/reg_apb_master_wdog.sv | 30 +++
 rtl/reg_apb_master.sv | 123 ++++++++++++
 tb/tb_reg_apb_master.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_apb_pkg.sv
// Shared APB register-access types: transfer FSM states and the default protection value.
package reg_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/reg_apb_master_wdog.sv
// Wait-state watchdog: counts ACCESS wait cycles and flags when the limit is reached.
module reg_apb_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;

    // Saturates at the limit so a long stall cannot wrap back to a non-expired value.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count_en && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (wait_cnt == LIMIT);

endmodule

// File: rtl/reg_apb_master.sv
// APB4 initiator for register access: one command in, one SETUP/ACCESS transfer, one response out.
//
// state  | meaning
// IDLE   | req_rdy high, waiting for a command
// SETUP  | p_sel high, p_enable low, single cycle
// ACCESS | p_sel/p_enable high, waiting for p_ready or watchdog expiry
// RESP   | rsp_vld high, holding the result until rsp_rdy
module reg_apb_master
    import reg_apb_pkg::*;
#(
    parameter int         ADDR_WIDTH = 16,
    parameter int         DATA_WIDTH = 32,
    parameter int         TIMEOUT    = 255,
    parameter logic [2:0] PROT       = PROT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_strb,
    output logic                    rsp_vld,
    input  logic                    rsp_rdy,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic [ADDR_WIDTH-1:0]   p_addr,
    output logic [2:0]              p_prot,
    output logic                    p_sel,
    output logic                    p_enable,
    output logic                    p_write,
    output logic [DATA_WIDTH-1:0]   p_wdata,
    output logic [DATA_WIDTH/8-1:0] p_strb,
    input  logic                    p_ready,
    input  logic [DATA_WIDTH-1:0]   p_rdata,
    input  logic                    p_slverr
);

    apb_state_e state;
    logic       wd_clear;
    logic       wd_count;
    logic       wd_expired;

    assign wd_clear = (state == IDLE) && req_vld && req_rdy;
    assign wd_count = (state == ACCESS) && !p_ready;
    assign p_prot   = PROT;

    reg_apb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_rdy   <= 1'b0;
            rsp_vld   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            p_sel     <= 1'b0;
            p_enable  <= 1'b0;
            p_write   <= 1'b0;
            p_addr    <= '0;
            p_wdata   <= '0;
            p_strb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_vld && req_rdy) begin
                        req_rdy <= 1'b0;
                        p_addr  <= req_addr;
                        p_write <= req_write;
                        p_wdata <= req_wdata;
                        p_strb  <= req_write ? req_strb : '0;
                        p_sel   <= 1'b1;
                        state   <= SETUP;
                    end else begin
                        req_rdy <= 1'b1;
                    end
                end
                SETUP: begin
                    p_enable <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    // p_ready takes priority over a watchdog expiry in the same cycle.
                    if (p_ready) begin
                        p_sel     <= 1'b0;
                        p_enable  <= 1'b0;
                        rsp_vld   <= 1'b1;
                        rsp_rdata <= p_write ? '0 : p_rdata;
                        rsp_err   <= p_slverr;
                        state     <= RESP;
                    end else if (wd_expired) begin
                        p_sel     <= 1'b0;
                        p_enable  <= 1'b0;
                        rsp_vld   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_rdy) begin
                        rsp_vld   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_rdy   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_apb_master.sv
// Self-checking bench for reg_apb_master with a wait-programmable APB responder and a response scoreboard.
module tb_reg_apb_master;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld, req_rdy, req_write;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_vld, rsp_rdy, rsp_err;
    logic [31:0] rsp_rdata;
    logic [15:0] p_addr;
    logic [2:0]  p_prot;
    logic        p_sel, p_enable, p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_ready, p_slverr;
    logic [31:0] p_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    reg_apb_master #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .TIMEOUT    (TIMEOUT),
        .PROT       (3'b000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .p_addr    (p_addr),
        .p_prot    (p_prot),
        .p_sel     (p_sel),
        .p_enable  (p_enable),
        .p_write   (p_write),
        .p_wdata   (p_wdata),
        .p_strb    (p_strb),
        .p_ready   (p_ready),
        .p_rdata   (p_rdata),
        .p_slverr  (p_slverr)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_val({tag, "_req_rdy"},   req_rdy,   0);
        chk_val({tag, "_rsp_vld"},   rsp_vld,   0);
        chk_val({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk_val({tag, "_rsp_err"},   rsp_err,   0);
        chk_val({tag, "_p_sel"},     p_sel,     0);
        chk_val({tag, "_p_enable"},  p_enable,  0);
        chk_val({tag, "_p_write"},   p_write,   0);
        chk_val({tag, "_p_addr"},    p_addr,    0);
        chk_val({tag, "_p_wdata"},   p_wdata,   0);
        chk_val({tag, "_p_strb"},    p_strb,    0);
    endtask

    // waits = wait states before p_ready; waits > TIMEOUT means the responder never answers.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int waits, input logic [31:0] rd,
                           input logic serr, input int hold);
        exp_t        e;
        int          n_acc;
        int          k;
        int          j;
        logic        got;
        logic [3:0]  exp_strb;
        exp_strb = wr ? st : 4'h0;
        if (waits <= TIMEOUT) begin
            n_acc   = waits + 1;
            e.err   = serr;
            e.rdata = wr ? 32'h0 : rd;
        end else begin
            n_acc   = TIMEOUT + 1;
            e.err   = 1'b1;
            e.rdata = 32'h0;
        end
        e.lat = n_acc + 2;

        @(negedge clk);
        k = 0;
        while (!req_rdy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk_val("idle_req_rdy", req_rdy, 1);
        req_vld   = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_strb  = st;
        sb.push_back(e);

        k   = 0;
        j   = 0;
        got = 1'b0;
        while (!got && k < 40) begin
            @(negedge clk);
            k++;
            req_vld   = 1'b0;
            req_write = 1'($urandom);
            req_addr  = 16'($urandom);
            req_wdata = $urandom;
            req_strb  = 4'($urandom);
            p_ready   = 1'b0;
            p_slverr  = 1'($urandom);
            p_rdata   = $urandom;
            if (rsp_vld) begin
                got = 1'b1;
            end else if (k == 1) begin
                chk_val("setup_sel", p_sel, 1);
                chk_val("setup_en", p_enable, 0);
                chk_val("busy_req_rdy", req_rdy, 0);
            end else if (p_sel && p_enable) begin
                j++;
                chk_val("acc_addr", p_addr, addr);
                chk_val("acc_wdata", p_wdata, wd);
                chk_val("acc_strb", p_strb, exp_strb);
                chk_val("acc_write", p_write, wr);
                chk_val("acc_prot", p_prot, 0);
                chk_val("acc_req_rdy", req_rdy, 0);
                if (j == waits + 1) begin
                    p_ready  = 1'b1;
                    p_rdata  = rd;
                    p_slverr = serr;
                end
            end else begin
                chk_val("acc_sel_en", {p_sel, p_enable}, 2'b11);
            end
        end

        chk_val("rsp_seen", got, 1);
        e = sb.pop_front();
        chk_val("acc_cycles", j, n_acc);
        chk_val("rsp_lat", k, e.lat);
        chk_val("rsp_err", rsp_err, e.err);
        chk_val("rsp_rdata", rsp_rdata, e.rdata);
        chk_val("rsp_p_sel", {p_sel, p_enable}, 0);
        chk_val("rsp_req_rdy", req_rdy, 0);

        rsp_rdy = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk_val("bp_vld", rsp_vld, 1);
            chk_val("bp_rdata", rsp_rdata, e.rdata);
            chk_val("bp_err", rsp_err, e.err);
            chk_val("bp_req_rdy", req_rdy, 0);
        end
        rsp_rdy = 1'b1;
        @(negedge clk);
        rsp_rdy = 1'b0;
        chk_val("post_rsp_vld", rsp_vld, 0);
        chk_val("post_req_rdy", req_rdy, 1);
    endtask

    initial begin
        req_vld   = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_rdy   = 1'b0;
        p_ready   = 1'b0;
        p_rdata   = '0;
        p_slverr  = 1'b0;
        rst       = 1'b1;

        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        chk_val("rst_rel_req_rdy", req_rdy, 1);

        run_txn(1'b1, 16'h0004, 32'hA5A5_1234, 4'hF, 0, 32'h1111_2222, 1'b0, 0);
        run_txn(1'b0, 16'h0010, 32'h0BAD_F00D, 4'hF, 3, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(1'b0, 16'h0020, 32'h0000_0000, 4'h0, 100, 32'hCAFE_0001, 1'b0, 0);
        run_txn(1'b1, 16'h0024, 32'h5555_AAAA, 4'h3, 1, 32'h7777_7777, 1'b1, 0);
        run_txn(1'b0, 16'h0028, 32'h0000_0000, 4'h0, TIMEOUT, 32'h1357_9BDF, 1'b0, 0);
        run_txn(1'b0, 16'h002C, 32'h0000_0000, 4'h0, 0, 32'h2468_ACE0, 1'b0, 10);

        for (int i = 0; i < 6; i++) begin
            run_txn(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom),
                    int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
        end

        // Reset pulsed while the responder is stalling in ACCESS.
        @(negedge clk);
        chk_val("mid_idle_req_rdy", req_rdy, 1);
        req_vld   = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0040;
        req_wdata = 32'h0;
        req_strb  = 4'h0;
        @(negedge clk);
        req_vld = 1'b0;
        @(negedge clk);
        chk_val("mid_access", {p_sel, p_enable}, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("mid_rst");
        rst = 1'b0;
        @(negedge clk);
        chk_val("mid_rel_req_rdy", req_rdy, 1);
        chk_val("mid_rel_rsp_vld", rsp_vld, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk_val("mid_no_rsp", {rsp_vld, p_sel, p_enable}, 0);
        end

        run_txn(1'b0, 16'h0044, 32'h0, 4'h0, 0, 32'h0F0F_F0F0, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit: got timeout, want completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
